as6d_ram_scrub_ctrl: RTL and testbench
======================================

Name: as6d_ram_scrub_ctrl

Overview:
- Initiator-side maintenance engine for an ECC-protected 1R1W RAM wrapper; drives the wrapper's write port (CSA/WEA/AA/DA) and read port (CSB/REB/AB) and consumes QB plus the SINGLE/DOUBLE error flags.
- After reset it can write ECC-clean zeros to every address (init). It then walks the array periodically, reading each word and writing back the corrected data on a single-bit error.
- Sits beside the functional client. The integration mux gives the functional client priority; the scrubber yields whenever func_req is high.

Parameters:
- ADDR_WIDTH, 12, RAM address width
- DATA_WIDTH, 128, RAM data width
- RAM_DEPTH, 1<<ADDR_WIDTH, number of words walked (last address RAM_DEPTH-1)
- RD_LATENCY, 2, cycles from CSB/REB/AB to QB/flags valid
- CNT_WIDTH, 16, width of error counters and interval

Ports:
- clk  in  1  single clock for both RAM ports
- rst  in  1  synchronous reset, active-high
- init_start  in  1  pulse: begin full-array zero init
- scrub_en  in  1  level: enable periodic scrub walk
- scrub_interval  in  CNT_WIDTH  idle cycles between scrub reads
- func_req  in  1  functional client owns RAM ports this cycle
- func_wr_en  in  1  functional write this cycle
- func_wr_addr  in  ADDR_WIDTH  functional write address
- mem_csa, mem_wea  out  1  write-port chip select / write enable
- mem_aa  out  ADDR_WIDTH  write address
- mem_da  out  DATA_WIDTH  write data
- mem_csb, mem_reb  out  1  read-port chip select / read enable
- mem_ab  out  ADDR_WIDTH  read address
- mem_qb  in  DATA_WIDTH  corrected read data
- mem_sbe, mem_dbe  in  1  single/double-bit error flags, aligned with mem_qb
- busy  out  1  scrubber is in any state except IDLE
- init_done  out  1  sticky once init completes; cleared by init_start or rst
- sbe_cnt, dbe_cnt  out  CNT_WIDTH  saturating error counters
- dbe_addr  out  ADDR_WIDTH  address of the most recent double-bit error
- dbe_irq  out  1  one-cycle pulse per double-bit error

Behaviour:
- Reset: all mem_* strobes 0, addresses and data 0, counters 0, init_done 0, dbe_irq 0, busy 0, FSM in IDLE, walk pointer 0, interval counter 0.
- All outputs are registered. No mem_* strobe is asserted in a cycle where func_req=1; the FSM holds its state and retries the following cycle.
- IDLE:
  - init_start → INIT with ptr=0.
  - Else, if scrub_en and interval counter ≥ scrub_interval → RD.
  - The interval counter increments while idle with scrub_en=1 and clears on leaving IDLE.
- INIT:
  - Each granted cycle writes mem_da=0 at ptr and increments ptr.
  - After the write at RAM_DEPTH-1: set init_done, ptr wraps to 0, go to IDLE.
  - init_start during INIT restarts from 0.
- RD: one granted cycle of csb=reb=1, ab=ptr; capture the address; go to RD_WAIT.
- RD_WAIT:
  - Waits exactly RD_LATENCY cycles, then samples mem_qb/mem_sbe/mem_dbe.
  - If sbe and not dbe: increment sbe_cnt, latch mem_qb, go to WB.
  - If dbe: increment dbe_cnt, set dbe_addr, pulse dbe_irq, no write-back.
  - In either case, ptr advances with wrap RAM_DEPTH-1→0, then go to IDLE (or to IDLE after WB).
- Collision: a functional write with func_wr_addr equal to the captured address, seen any cycle from RD through WB issue, sets an abort bit. WB is then skipped, while the error is still counted.
- WB: one granted cycle of csa=wea=1, aa=captured address, da=latched data; then IDLE.
- Counters saturate at all-ones and never wrap.
- scrub_en deasserting mid-walk finishes the current read/WB, then stays in IDLE. init_start has priority over scrub when both are pending in IDLE.
- rst asserted mid-operation: the next cycle is at reset values, with no partial strobes; init must be restarted.

Optional Feature:
- Macro AS6D_SCRUB_FAULT_CNT_EN.
- When defined:
  - Adds input mem_ecc_fault (1) and output fault_cnt (CNT_WIDTH).
  - mem_ecc_fault is sampled with the flags.
  - fault_cnt is saturating, and a fault also pulses dbe_irq.
- When undefined: no port, no counter, and flag handling is exactly as above.

Decomposition:
- Shared package as6d_scrub_pkg holds:
  - the FSM state enum (IDLE, INIT, RD, RD_WAIT, WB);
  - the saturating-increment function;
  - the default RD_LATENCY constant.
- One sub-module, as6d_scrub_sat_cnt: a parameterised saturating counter, instanced for sbe, dbe and the optional fault counter.

Test Plan:
- rst then init_start, func_req=0 → 4096 consecutive writes of 0 at addr 0..4095, init_done=1 on the cycle after the last write, busy falls.
- scrub_en=1, scrub_interval=4, model returns sbe=1 at addr 0x010 with qb=0xA5..A5 → WB at aa=0x010 with da=0xA5..A5, sbe_cnt=1.
- dbe=1 at addr 0x020 → no csa, dbe_addr=0x020, dbe_irq high exactly 1 cycle, dbe_cnt=1, walk continues at 0x021.
- func_req held high 10 cycles during a pending RD → no mem_* strobes for 10 cycles, RD issues the cycle after release.
- sbe at 0x030 with func_wr_en, func_wr_addr=0x030 during RD_WAIT → no WB, sbe_cnt still increments.
- rst pulse at INIT address 0x800 → outputs at reset values next cycle, init_done=0; sbe_cnt forced to 0xFFFF then another sbe → stays 0xFFFF.

Source files
------------

// File: rtl/as6d_ram_scrub_ctrl_pkg.sv
// Shared types and helpers for the RAM scrub controller.
// The optional fault counter is enabled with AS6D_SCRUB_FAULT_CNT_EN.
package as6d_scrub_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RD,
        RD_WAIT,
        WB
    } scrub_state_t;

    localparam int DEF_RD_LATENCY = 2;

    // Widths up to 32 bits; callers pass their own all-ones ceiling.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
        return (val >= max) ? max : val + 32'd1;
    endfunction

endpackage

// File: rtl/as6d_ram_scrub_ctrl_if.sv
// RAM wrapper port bundle: write port A, read port B, corrected data and ECC flags.
// mem_ecc_fault exists only when AS6D_SCRUB_FAULT_CNT_EN is defined.
interface as6d_ram_scrub_ctrl_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 128
) ();
    logic                  csa;
    logic                  wea;
    logic [ADDR_WIDTH-1:0] aa;
    logic [DATA_WIDTH-1:0] da;
    logic                  csb;
    logic                  reb;
    logic [ADDR_WIDTH-1:0] ab;
    logic [DATA_WIDTH-1:0] qb;
    logic                  sbe;
    logic                  dbe;
`ifdef AS6D_SCRUB_FAULT_CNT_EN
    logic                  ecc_fault;
`endif

    modport master (
        output csa, wea, aa, da, csb, reb, ab,
`ifdef AS6D_SCRUB_FAULT_CNT_EN
        input  ecc_fault,
`endif
        input  qb, sbe, dbe
    );

    modport slave (
        input  csa, wea, aa, da, csb, reb, ab,
`ifdef AS6D_SCRUB_FAULT_CNT_EN
        output ecc_fault,
`endif
        output qb, sbe, dbe
    );
endinterface

// File: rtl/as6d_ram_scrub_ctrl_sat_cnt.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module as6d_scrub_sat_cnt
    import as6d_scrub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (inc)
            cnt <= WIDTH'(sat_inc(32'(cnt), 32'(CNT_MAX)));
    end
endmodule

// File: rtl/as6d_ram_scrub_ctrl.sv
// Zero-init and periodic ECC scrub engine for a 1R1W RAM wrapper; yields to func_req.
// Optional fault counter under AS6D_SCRUB_FAULT_CNT_EN.
//
// state   | meaning
// IDLE    | counting the scrub interval, waiting for init_start or scrub slot
// INIT    | writing zeros at ptr, one word per granted cycle
// RD      | issuing the scrub read at ptr when granted
// RD_WAIT | read in flight; flags sampled when wait_cnt reaches 0
// WB      | writing corrected data back to the captured address
module as6d_ram_scrub_ctrl
    import as6d_scrub_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 128,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_start,
    input  logic                  scrub_en,
    input  logic [CNT_WIDTH-1:0]  scrub_interval,
    input  logic                  func_req,
    input  logic                  func_wr_en,
    input  logic [ADDR_WIDTH-1:0] func_wr_addr,
    as6d_ram_scrub_ctrl_if.master mem,
    output logic                  busy,
    output logic                  init_done,
    output logic [CNT_WIDTH-1:0]  sbe_cnt,
    output logic [CNT_WIDTH-1:0]  dbe_cnt,
    output logic [ADDR_WIDTH-1:0] dbe_addr,
`ifdef AS6D_SCRUB_FAULT_CNT_EN
    output logic [CNT_WIDTH-1:0]  fault_cnt,
`endif
    output logic                  dbe_irq
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;
    localparam logic [7:0]            WAIT_LOAD = 8'(RD_LATENCY);

    scrub_state_t          state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic [CNT_WIDTH-1:0]  ival_cnt;
    logic [7:0]            wait_cnt;
    logic                  abort;
    logic                  init_last;

    logic [ADDR_WIDTH-1:0] ptr_next;
    logic                  hit, rd_sample, sbe_inc, dbe_inc, wb_go, err_irq;

    assign ptr_next  = (ptr == LAST_ADDR) ? '0 : ptr + ADDR_WIDTH'(1);
    // Before capture (RD) the pending read address is still ptr.
    assign hit       = func_wr_en
                     && (func_wr_addr == ((state == RD) ? ptr : cap_addr))
                     && (state == RD || state == RD_WAIT || state == WB);
    assign rd_sample = (state == RD_WAIT) && (wait_cnt == 8'd0);
    assign sbe_inc   = rd_sample && mem.sbe && !mem.dbe;
    assign dbe_inc   = rd_sample && mem.dbe;
    assign wb_go     = sbe_inc && !abort && !hit;

`ifdef AS6D_SCRUB_FAULT_CNT_EN
    logic fault_inc;
    assign fault_inc = rd_sample && mem.ecc_fault;
    assign err_irq   = dbe_inc || fault_inc;

    as6d_scrub_sat_cnt #(.WIDTH(CNT_WIDTH)) u_fault_cnt (
        .clk(clk), .rst(rst), .inc(fault_inc), .cnt(fault_cnt)
    );
`else
    assign err_irq   = dbe_inc;
`endif

    as6d_scrub_sat_cnt #(.WIDTH(CNT_WIDTH)) u_sbe_cnt (
        .clk(clk), .rst(rst), .inc(sbe_inc), .cnt(sbe_cnt)
    );

    as6d_scrub_sat_cnt #(.WIDTH(CNT_WIDTH)) u_dbe_cnt (
        .clk(clk), .rst(rst), .inc(dbe_inc), .cnt(dbe_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cap_addr  <= '0;
            wb_data   <= '0;
            ival_cnt  <= '0;
            wait_cnt  <= '0;
            abort     <= 1'b0;
            init_last <= 1'b0;
            busy      <= 1'b0;
            init_done <= 1'b0;
            dbe_addr  <= '0;
            dbe_irq   <= 1'b0;
            mem.csa   <= 1'b0;
            mem.wea   <= 1'b0;
            mem.aa    <= '0;
            mem.da    <= '0;
            mem.csb   <= 1'b0;
            mem.reb   <= 1'b0;
            mem.ab    <= '0;
        end else begin
            mem.csa   <= 1'b0;
            mem.wea   <= 1'b0;
            mem.csb   <= 1'b0;
            mem.reb   <= 1'b0;
            dbe_irq   <= 1'b0;
            // init_done trails the final init write strobe by one cycle.
            init_last <= 1'b0;
            init_done <= init_done | init_last;
            if (hit)
                abort <= 1'b1;

            case (state)
                IDLE: begin
                    if (init_start) begin
                        state     <= INIT;
                        ptr       <= '0;
                        ival_cnt  <= '0;
                        init_done <= 1'b0;
                        busy      <= 1'b1;
                    end else if (scrub_en && ival_cnt >= scrub_interval) begin
                        state    <= RD;
                        ival_cnt <= '0;
                        abort    <= 1'b0;
                        busy     <= 1'b1;
                    end else if (scrub_en) begin
                        ival_cnt <= CNT_WIDTH'(sat_inc(32'(ival_cnt), 32'(CNT_MAX)));
                    end
                end
                INIT: begin
                    if (init_start) begin
                        ptr       <= '0;
                        init_done <= 1'b0;
                    end else if (!func_req) begin
                        mem.csa <= 1'b1;
                        mem.wea <= 1'b1;
                        mem.aa  <= ptr;
                        mem.da  <= '0;
                        ptr     <= ptr_next;
                        if (ptr == LAST_ADDR) begin
                            init_last <= 1'b1;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end
                    end
                end
                RD: begin
                    if (!func_req) begin
                        mem.csb  <= 1'b1;
                        mem.reb  <= 1'b1;
                        mem.ab   <= ptr;
                        cap_addr <= ptr;
                        wait_cnt <= WAIT_LOAD;
                        state    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (wait_cnt != 8'd0) begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end else begin
                        ptr <= ptr_next;
                        if (dbe_inc)
                            dbe_addr <= cap_addr;
                        if (err_irq)
                            dbe_irq <= 1'b1;
                        if (wb_go) begin
                            wb_data <= mem.qb;
                            state   <= WB;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                WB: begin
                    if (abort || hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!func_req) begin
                        mem.csa <= 1'b1;
                        mem.wea <= 1'b1;
                        mem.aa  <= cap_addr;
                        mem.da  <= wb_data;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_as6d_ram_scrub_ctrl.sv
// Directed bench for as6d_ram_scrub_ctrl: init sweep, scrub error handling, yield,
// collision abort, mid-init reset, and counter saturation on a narrow-counter instance.
module tb_as6d_ram_scrub_ctrl;
    import as6d_scrub_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic        rst, init_start, scrub_en, func_req, func_wr_en;
    logic [15:0] scrub_interval;
    logic [11:0] func_wr_addr;
    logic        busy, init_done, dbe_irq;
    logic [15:0] sbe_cnt, dbe_cnt;
    logic [11:0] dbe_addr;

    as6d_ram_scrub_ctrl_if #(.ADDR_WIDTH(12), .DATA_WIDTH(128)) m ();

`ifdef AS6D_SCRUB_FAULT_CNT_EN
    logic [15:0] fault_cnt;
    logic [3:0]  fault_cnt2;
    assign m.ecc_fault  = 1'b0;
    assign m2.ecc_fault = 1'b0;
`endif

    as6d_ram_scrub_ctrl dut (
        .clk(clk), .rst(rst), .init_start(init_start), .scrub_en(scrub_en),
        .scrub_interval(scrub_interval), .func_req(func_req), .func_wr_en(func_wr_en),
        .func_wr_addr(func_wr_addr), .mem(m), .busy(busy), .init_done(init_done),
        .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt), .dbe_addr(dbe_addr),
`ifdef AS6D_SCRUB_FAULT_CNT_EN
        .fault_cnt(fault_cnt),
`endif
        .dbe_irq(dbe_irq)
    );

    // RAM read model: data and flags appear two cycles after the read strobe cycle.
    logic        p1_v, p2_v;
    logic [11:0] p1_a, p2_a;
    always @(posedge clk) begin
        p1_v <= m.csb & m.reb;
        p1_a <= m.ab;
        p2_v <= p1_v;
        p2_a <= p1_a;
    end

    always_comb begin
        m.qb  = '0;
        m.sbe = 1'b0;
        m.dbe = 1'b0;
        if (p2_v === 1'b1) begin
            case (p2_a)
                12'h010: begin m.qb = {16{8'hA5}}; m.sbe = 1'b1; end
                12'h020: begin m.dbe = 1'b1; end
                12'h030: begin m.qb = {16{8'h3C}}; m.sbe = 1'b1; end
                default: ;
            endcase
        end
    end

    // Narrow-counter instance whose RAM always reports a single-bit error.
    logic       scrub_en2, busy2, init_done2, dbe_irq2;
    logic [3:0] sbe_cnt2, dbe_cnt2, dbe_addr2;
    as6d_ram_scrub_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) m2 ();
    assign m2.qb  = 8'h5A;
    assign m2.sbe = 1'b1;
    assign m2.dbe = 1'b0;

    as6d_ram_scrub_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .CNT_WIDTH(4)) dut2 (
        .clk(clk), .rst(rst), .init_start(1'b0), .scrub_en(scrub_en2),
        .scrub_interval(4'd0), .func_req(1'b0), .func_wr_en(1'b0),
        .func_wr_addr(4'd0), .mem(m2), .busy(busy2), .init_done(init_done2),
        .sbe_cnt(sbe_cnt2), .dbe_cnt(dbe_cnt2), .dbe_addr(dbe_addr2),
`ifdef AS6D_SCRUB_FAULT_CNT_EN
        .fault_cnt(fault_cnt2),
`endif
        .dbe_irq(dbe_irq2)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_read(input int max_cyc, output logic [11:0] a);
        a = 'x;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (m.csb === 1'b1 && m.reb === 1'b1) begin
                a = m.ab;
                return;
            end
        end
    endtask

    task automatic read_until(input logic [11:0] target, output logic [11:0] a);
        a = 'x;
        for (int k = 0; k < 80; k++) begin
            next_read(40, a);
            if (a === target || $isunknown(a)) return;
        end
    endtask

    task automatic check_reset_state(input string pfx);
        chk({pfx, "_csa"},      m.csa,     1'b0);
        chk({pfx, "_wea"},      m.wea,     1'b0);
        chk({pfx, "_aa"},       m.aa,      12'h000);
        chk({pfx, "_da"},       m.da,      128'h0);
        chk({pfx, "_csb"},      m.csb,     1'b0);
        chk({pfx, "_ab"},       m.ab,      12'h000);
        chk({pfx, "_busy"},     busy,      1'b0);
        chk({pfx, "_init_done"},init_done, 1'b0);
        chk({pfx, "_sbe_cnt"},  sbe_cnt,   16'h0000);
        chk({pfx, "_dbe_cnt"},  dbe_cnt,   16'h0000);
        chk({pfx, "_dbe_addr"}, dbe_addr,  12'h000);
        chk({pfx, "_dbe_irq"},  dbe_irq,   1'b0);
    endtask

    initial begin
        logic [11:0] a;
        bit          seq_ok, csa_seen, strobe_seen, found;
        int          irq_n;

        rst = 1'b1; init_start = 1'b0; scrub_en = 1'b0; scrub_en2 = 1'b0;
        scrub_interval = 16'd4; func_req = 1'b0; func_wr_en = 1'b0; func_wr_addr = '0;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        rst = 1'b0;

        // Full-array zero init.
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m.csa === 1'b1) begin found = 1'b1; break; end
        end
        chk("init_first_write", found, 1'b1);
        seq_ok = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            if (i > 0) @(negedge clk);
            if (!(m.csa === 1'b1 && m.wea === 1'b1 && m.aa === 12'(i) && m.da === 128'h0))
                seq_ok = 1'b0;
        end
        chk("init_sequence", seq_ok, 1'b1);
        chk("init_done_at_last_write", init_done, 1'b0);
        @(negedge clk);
        chk("init_done_after", init_done, 1'b1);
        chk("init_csa_stops", m.csa, 1'b0);
        chk("init_busy_falls", busy, 1'b0);

        // Scrub walk starts at 0; single-bit error at 0x010 gets written back.
        scrub_en = 1'b1;
        next_read(40, a);
        chk("first_rd_addr", a, 12'h000);
        read_until(12'h010, a);
        chk("rd_0x010", a, 12'h010);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m.csa === 1'b1) begin found = 1'b1; break; end
        end
        chk("wb_issued", found, 1'b1);
        chk("wb_wea", m.wea, 1'b1);
        chk("wb_aa", m.aa, 12'h010);
        chk("wb_da", m.da, {16{8'hA5}});
        chk("sbe_cnt_1", sbe_cnt, 16'd1);

        // Double-bit error at 0x020: count, irq pulse, address, no write-back.
        read_until(12'h020, a);
        chk("rd_0x020", a, 12'h020);
        irq_n = 0; csa_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dbe_irq === 1'b1) irq_n++;
            if (m.csa === 1'b1) csa_seen = 1'b1;
        end
        chk("dbe_irq_pulses", irq_n, 1);
        chk("dbe_no_wb", csa_seen, 1'b0);
        chk("dbe_addr", dbe_addr, 12'h020);
        chk("dbe_cnt_1", dbe_cnt, 16'd1);
        chk("sbe_cnt_still_1", sbe_cnt, 16'd1);
        next_read(40, a);
        chk("walk_after_dbe", a, 12'h021);

        // Functional client holds the RAM for 10 cycles across the next scrub read.
        func_req = 1'b1;
        strobe_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m.csa === 1'b1 || m.csb === 1'b1 || m.reb === 1'b1 || m.wea === 1'b1)
                strobe_seen = 1'b1;
        end
        chk("yield_no_strobes", strobe_seen, 1'b0);
        func_req = 1'b0;
        @(negedge clk);
        chk("rd_after_release_csb", m.csb, 1'b1);
        chk("rd_after_release_ab", m.ab, 12'h022);

        // Functional write to the in-flight scrub address cancels the write-back.
        read_until(12'h030, a);
        chk("rd_0x030", a, 12'h030);
        func_req = 1'b1; func_wr_en = 1'b1; func_wr_addr = 12'h030;
        @(negedge clk);
        func_req = 1'b0; func_wr_en = 1'b0; func_wr_addr = '0;
        csa_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m.csa === 1'b1) csa_seen = 1'b1;
        end
        chk("collision_no_wb", csa_seen, 1'b0);
        chk("collision_sbe_cnt_2", sbe_cnt, 16'd2);
        next_read(40, a);
        chk("walk_after_collision", a, 12'h031);

        // Disable scrub: the read in flight completes and the engine parks.
        scrub_en = 1'b0;
        repeat (10) @(negedge clk);
        chk("scrub_off_idle", busy, 1'b0);

        // Reset in the middle of init.
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (m.csa === 1'b1 && m.aa === 12'h800) begin found = 1'b1; break; end
        end
        chk("init_reached_0x800", found, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midrst");
        rst = 1'b0;
        strobe_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (m.csa === 1'b1 || m.csb === 1'b1 || busy === 1'b1) strobe_seen = 1'b1;
        end
        chk("no_resume_after_rst", strobe_seen, 1'b0);

        // Narrow counter: ~30 single-bit errors must pin sbe_cnt at 4'hF.
        scrub_en2 = 1'b1;
        repeat (200) @(negedge clk);
        chk("sat_sbe_cnt", sbe_cnt2, 4'hF);
        chk("sat_dbe_cnt", dbe_cnt2, 4'h0);
        repeat (30) @(negedge clk);
        chk("sat_sbe_cnt_hold", sbe_cnt2, 4'hF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
